sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Three-port fixed/round-robin arbiter sharing the single SDRAM controller port between the PPU CHR bridge, the CPU PRG bridge and the MCU loader. Requesters issue one-cycle command pulses; the arbiter latches each command, serialises them onto the controller's request/acknowledge handshake and returns a one-cycle acknowledge plus read data to the owning port. It sits between the cartridge bus bridges and the SDRAM controller.

## Interface
- ADDR_BITS, 22, SDRAM word-address width
- clk  in  1  system clock; everything is sampled on its rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  3  per-port command pulse, one cycle; index 0 = CHR, 1 = PRG, 2 = loader
- we  in  3  per-port write enable (0 = read), qualified by req
- address  in  3×ADDR_BITS  per-port word address
- data_write  in  3×16  per-port write data
- wm  in  3×2  per-port byte write mask (1 = byte masked)
- ack  out  3  per-port completion pulse, one cycle
- data_read  out  16  read data of the most recent completed read, valid when any ack is high
- err  out  3  sticky per-port overflow flag
- mem_req  out  1  controller command pulse, one cycle
- mem_we, mem_address, mem_data_write, mem_wm  out  1/ADDR_BITS/16/2  controller command fields, held stable from mem_req until mem_ack
- mem_ack  in  1  controller completion pulse; mem_data_read valid that cycle
- mem_data_read  in  16  controller read data

## Operation
- Per port: a pending flag plus command registers (we, address, data_write, wm).
- When req[i] is sampled high and port i is neither pending nor in flight, its command is captured and pending[i] is set.
- When req[i] is sampled high while port i is pending or in flight, the request is dropped, the stored command is unchanged and err[i] is set. err is cleared only by reset.
- FSM states:
  - IDLE: if any port is pending, grant it, load the mem_* fields from its registers, clear its pending flag, assert mem_req, then go to WAIT. If nothing is pending, stay in IDLE.
  - WAIT: mem_req is 0. On mem_ack, register data_read ← mem_data_read if the granted command was a read (otherwise data_read holds its value), pulse ack[grant], then go to IDLE.
- Grant priority:
  - Port 0 always wins.
  - Ports 1 and 2 alternate using a round-robin bit that favours the port not granted last. The bit updates only when port 1 or port 2 is granted.
- mem_ack sampled outside WAIT is ignored.
- A port may issue a new req in the same cycle its ack is high; that req is accepted.
- Reset mid-transaction: the in-flight command is abandoned and no ack is issued. The controller must also be reset by the same reset.

## Timing
- Reset values:
  - state IDLE; pending, err, ack = 0; mem_req = 0
  - mem_we = 0; mem_address, mem_data_write, data_read = 0; mem_wm = 0
  - round-robin bit favours port 1
- Request latency, idle arbiter: req high at edge t → pending at t; mem_req is high during the cycle following edge t+1.
- Completion: mem_ack sampled at edge k → ack and data_read updated after edge k, for one cycle. The earliest next mem_req is after edge k+1, so back-to-back transactions are spaced by one IDLE cycle.
- Worst-case wait for port 0: one in-flight transaction plus 2 cycles.
- Worst-case wait for ports 1 and 2: bounded only while port 0's request rate leaves gaps. This is a documented property; no starvation guard is implemented.

## Test plan
- Reset, then port 0 read to 0x000123 with mem_ack returned 3 cycles after mem_req and mem_data_read = 0xBEEF → exactly one mem_req with mem_we = 0 and mem_address = 0x000123; ack[0] one cycle; data_read = 0xBEEF.
- All three ports pulse req in the same cycle (port 1 write 0x1111 with wm = 2'b01) → grant order 0, 1, 2; each ack follows its own mem_ack; mem_data_write = 0x1111 and mem_wm = 01 during port 1's transaction.
- Ports 1 and 2 request repeatedly while port 0 is idle → grants alternate 1, 2, 1, 2; port 0 injected mid-sequence is served next.
- Port 2 pulses req twice before its ack → second request dropped; err[2] = 1 and stays high; only one mem_req is issued for port 2.
- Spurious mem_ack in IDLE → no ack and no state change; new req in the ack cycle → accepted and issued.
- reset asserted during WAIT → all outputs return to their reset values immediately; after release, a new port 1 request completes normally.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bundle of the three requester ports and the single SDRAM controller port
// that sdram_arbiter sits between.
interface sdram_arbiter_if #(
    parameter int unsigned ADDR_BITS = 22
);
    logic [2:0]                    req;
    logic [2:0]                    we;
    logic [2:0][ADDR_BITS-1:0]     address;
    logic [2:0][15:0]              data_write;
    logic [2:0][1:0]               wm;
    logic [2:0]                    ack;
    logic [15:0]                   data_read;
    logic [2:0]                    err;

    logic                          mem_req;
    logic                          mem_we;
    logic [ADDR_BITS-1:0]          mem_address;
    logic [15:0]                   mem_data_write;
    logic [1:0]                    mem_wm;
    logic                          mem_ack;
    logic [15:0]                   mem_data_read;

    // Arbiter side
    modport slave (
        input  req, we, address, data_write, wm, mem_ack, mem_data_read,
        output ack, data_read, err, mem_req, mem_we, mem_address, mem_data_write, mem_wm
    );

    // Requester / controller side
    modport master (
        output req, we, address, data_write, wm, mem_ack, mem_data_read,
        input  ack, data_read, err, mem_req, mem_we, mem_address, mem_data_write, mem_wm
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Serialises CHR (0), PRG (1) and loader (2) command pulses onto one SDRAM
// controller handshake; port 0 has fixed priority, ports 1/2 round-robin.
module sdram_arbiter #(
    parameter int unsigned ADDR_BITS = 22
) (
    input  logic           clk,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);
    localparam int unsigned NPORTS = 3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                            state, state_n;
    logic [NPORTS-1:0]                 pending;
    logic [NPORTS-1:0]                 cmd_we;
    logic [NPORTS-1:0][ADDR_BITS-1:0]  cmd_address;
    logic [NPORTS-1:0][15:0]           cmd_data_write;
    logic [NPORTS-1:0][1:0]            cmd_wm;
    logic [1:0]                        grant, grant_n;
    logic                              rr_favor2;
    logic                              issue, done;

    // Next state and grant selection
    always_comb begin
        state_n = state;
        grant_n = grant;
        issue   = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    issue   = 1'b1;
                    state_n = S_WAIT;
                    if (pending[0])
                        grant_n = 2'd0;
                    else if (pending[1] && (!pending[2] || !rr_favor2))
                        grant_n = 2'd1;
                    else
                        grant_n = 2'd2;
                end
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Command capture, controller command fields and completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending            <= '0;
            cmd_we             <= '0;
            cmd_address        <= '0;
            cmd_data_write     <= '0;
            cmd_wm             <= '0;
            grant              <= 2'd0;
            rr_favor2          <= 1'b0;
            bus.err            <= '0;
            bus.ack            <= '0;
            bus.data_read      <= 16'h0000;
            bus.mem_req        <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_data_write <= 16'h0000;
            bus.mem_wm         <= 2'b00;
        end else begin
            bus.ack     <= '0;
            bus.mem_req <= 1'b0;

            // A port that is still queued or on the bus cannot take another command
            for (int i = 0; i < NPORTS; i++) begin
                if (bus.req[i]) begin
                    if (pending[i] || (state == S_WAIT && grant == 2'(i))) begin
                        bus.err[i] <= 1'b1;
                    end else begin
                        pending[i]        <= 1'b1;
                        cmd_we[i]         <= bus.we[i];
                        cmd_address[i]    <= bus.address[i];
                        cmd_data_write[i] <= bus.data_write[i];
                        cmd_wm[i]         <= bus.wm[i];
                    end
                end
            end

            if (issue) begin
                grant              <= grant_n;
                pending[grant_n]   <= 1'b0;
                bus.mem_req        <= 1'b1;
                bus.mem_we         <= cmd_we[grant_n];
                bus.mem_address    <= cmd_address[grant_n];
                bus.mem_data_write <= cmd_data_write[grant_n];
                bus.mem_wm         <= cmd_wm[grant_n];
                if (grant_n == 2'd1)
                    rr_favor2 <= 1'b1;
                else if (grant_n == 2'd2)
                    rr_favor2 <= 1'b0;
            end

            if (done) begin
                bus.ack[grant] <= 1'b1;
                if (!bus.mem_we)
                    bus.data_read <= bus.mem_data_read;
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: a reference model of the arbitration rules
// plus a latency-configurable controller model driving the memory handshake.
module tb_sdram_arbiter;
    localparam int unsigned AB = 22;

    typedef struct { logic we; logic [AB-1:0] addr; logic [15:0] wd; logic [1:0] wm; int cyc; } iss_t;
    typedef struct { int port; logic [15:0] data; int cyc; } ack_t;

    logic clk = 1'b0;
    logic reset;

    sdram_arbiter_if #(.ADDR_BITS(AB)) bus();
    sdram_arbiter #(.ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    iss_t exp_iss[$], obs_iss[$];
    ack_t exp_ack[$], obs_ack[$];

    // Reference model: per-port queued/busy state, who is on the bus, last of 1/2 served
    iss_t        m_cmd[3];
    bit          m_pend[3];
    bit          m_busy[3];
    int          m_acc[3];
    int          m_inflight;
    int          m_last12;
    logic [2:0]  m_err;
    logic [15:0] m_rd;

    // Controller model
    iss_t        c_cmd;
    int          c_cnt;
    int          c_lat;
    logic [15:0] c_rdata;
    bit          c_acked;
    int          hold_bad;
    bit          rd_force;
    logic [15:0] rd_val;

    function automatic int onehot_idx(logic [2:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 9;
        endcase
    endfunction

    function automatic logic [AB-1:0] rand_addr(int p);
        return {2'(p), 20'($urandom)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0; m_busy[i] = 0; m_acc[i] = 0;
            m_cmd[i] = '{1'b0, '0, 16'h0, 2'b00, 0};
        end
        m_inflight = -1; m_last12 = 2; m_err = 3'b000; m_rd = 16'h0;
        c_cnt = 0; c_acked = 0; hold_bad = 0;
        exp_iss.delete(); obs_iss.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic tick();
        bit was_wait, e1, e2;
        int p;
        @(posedge clk);
        cyc++;
        #1;
        bus.req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bus.we[i]         = 1'($urandom);
            bus.address[i]    = AB'($urandom);
            bus.data_write[i] = 16'($urandom);
            bus.wm[i]         = 2'($urandom);
        end
        if (bus.ack !== 3'b000)
            obs_ack.push_back('{onehot_idx(bus.ack), bus.data_read, cyc});

        was_wait = (m_inflight >= 0);
        if (c_acked && was_wait) begin
            if (!m_cmd[m_inflight].we) m_rd = c_rdata;
            exp_ack.push_back('{m_inflight, m_rd, cyc});
            m_busy[m_inflight] = 0;
            m_inflight = -1;
        end
        c_acked = 0;
        bus.mem_ack = 1'b0;
        bus.mem_data_read = 16'($urandom);

        if (!was_wait) begin
            p  = -1;
            e1 = m_pend[1] && (m_acc[1] < cyc);
            e2 = m_pend[2] && (m_acc[2] < cyc);
            if (m_pend[0] && m_acc[0] < cyc) p = 0;
            else if (e1 && e2)               p = (m_last12 == 1) ? 2 : 1;
            else if (e1)                     p = 1;
            else if (e2)                     p = 2;
            if (p >= 0) begin
                exp_iss.push_back('{m_cmd[p].we, m_cmd[p].addr, m_cmd[p].wd, m_cmd[p].wm, cyc});
                m_pend[p] = 0;
                m_inflight = p;
                if (p != 0) m_last12 = p;
            end
        end

        if (bus.mem_req === 1'b1) begin
            c_cmd = '{bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm, cyc};
            obs_iss.push_back(c_cmd);
            c_cnt = c_lat;
            c_rdata = rd_force ? rd_val : 16'($urandom);
        end else if (c_cnt > 0) begin
            if ({bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm} !==
                {c_cmd.we, c_cmd.addr, c_cmd.wd, c_cmd.wm})
                hold_bad++;
            c_cnt--;
            if (c_cnt == 0) begin
                bus.mem_ack = 1'b1;
                bus.mem_data_read = c_rdata;
                c_acked = 1;
            end
        end
    endtask

    task automatic drive(int p, logic we, logic [AB-1:0] a, logic [15:0] d, logic [1:0] wm);
        bus.req[p] = 1'b1; bus.we[p] = we; bus.address[p] = a; bus.data_write[p] = d; bus.wm[p] = wm;
        if (m_busy[p]) m_err[p] = 1'b1;
        else begin
            m_busy[p] = 1; m_pend[p] = 1; m_acc[p] = cyc + 1;
            m_cmd[p] = '{we, a, d, wm, 0};
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 3'b000; bus.mem_ack = 1'b0;
        model_clear();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while ((m_busy[0] || m_busy[1] || m_busy[2]) && n < budget) begin tick(); n++; end
        vecs++;
        if (n >= budget) begin
            errs++;
            $display("FAIL %s_timeout: ports still busy %b%b%b after %0d cycles, required idle", name, m_busy[2], m_busy[1], m_busy[0], n);
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({bus.ack, bus.err, bus.mem_req} !== 7'b0) begin
            errs++; $display("FAIL reset_ctrl: ack/err/mem_req=%b, required 0", {bus.ack, bus.err, bus.mem_req});
        end
        vecs++;
        if ({bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm} !== 41'd0) begin
            errs++; $display("FAIL reset_fields: mem fields=%h, required 0", {bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm});
        end
        vecs++;
        if (bus.data_read !== 16'h0) begin
            errs++; $display("FAIL reset_data_read: got %h, required 0000", bus.data_read);
        end
        tick(); tick(); tick();
        vecs++;
        if (obs_iss.size() != 0) begin
            errs++; $display("FAIL reset_idle: %0d mem_req seen, required 0", obs_iss.size());
        end
    endtask

    task automatic test_single_read();
        int t0;
        do_reset();
        c_lat = 3; rd_force = 1; rd_val = 16'hBEEF;
        t0 = cyc;
        drive(0, 1'b0, 22'h000123, 16'h5555, 2'b00);
        wait_idle("single_read", 40);
        vecs++;
        if (obs_iss.size() != 1) begin
            errs++; $display("FAIL single_issue_count: got %0d, required 1", obs_iss.size());
        end else begin
            vecs++;
            if (obs_iss[0].we !== 1'b0 || obs_iss[0].addr !== 22'h000123 || obs_iss[0].cyc != t0 + 2) begin
                errs++; $display("FAIL single_issue: we=%b addr=%h cyc=%0d, required we=0 addr=000123 cyc=%0d", obs_iss[0].we, obs_iss[0].addr, obs_iss[0].cyc, t0 + 2);
            end
        end
        vecs++;
        if (obs_ack.size() != 1) begin
            errs++; $display("FAIL single_ack_count: got %0d ack cycles, required 1", obs_ack.size());
        end else begin
            vecs++;
            if (obs_ack[0].port != 0 || obs_ack[0].data !== 16'hBEEF || obs_ack[0].cyc != t0 + 6) begin
                errs++; $display("FAIL single_ack: port=%0d data=%h cyc=%0d, required port=0 data=beef cyc=%0d", obs_ack[0].port, obs_ack[0].data, obs_ack[0].cyc, t0 + 6);
            end
        end
        rd_force = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        c_lat = $urandom_range(1, 4);
        drive(0, 1'b0, rand_addr(0), 16'($urandom), 2'b00);
        drive(1, 1'b1, rand_addr(1), 16'h1111, 2'b01);
        drive(2, 1'b0, rand_addr(2), 16'($urandom), 2'b11);
        wait_idle("simultaneous", 60);
        vecs++;
        if (obs_ack.size() != 3 || obs_iss.size() != 3) begin
            errs++; $display("FAIL simul_counts: %0d issues %0d acks, required 3 and 3", obs_iss.size(), obs_ack.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vecs++;
                if (obs_ack[i].port != i || obs_ack[i].data !== exp_ack[i].data || obs_ack[i].cyc != obs_iss[i].cyc + c_lat + 1) begin
                    errs++; $display("FAIL simul_ack[%0d]: port=%0d data=%h cyc=%0d, required port=%0d data=%h cyc=%0d", i, obs_ack[i].port, obs_ack[i].data, obs_ack[i].cyc, i, exp_ack[i].data, obs_iss[i].cyc + c_lat + 1);
                end
                if (i > 0) begin
                    vecs++;
                    if (obs_iss[i].cyc != obs_ack[i-1].cyc + 1) begin
                        errs++; $display("FAIL simul_spacing[%0d]: issue cyc=%0d, required %0d", i, obs_iss[i].cyc, obs_ack[i-1].cyc + 1);
                    end
                end
            end
            vecs++;
            if (obs_iss[1].we !== 1'b1 || obs_iss[1].wd !== 16'h1111 || obs_iss[1].wm !== 2'b01) begin
                errs++; $display("FAIL simul_port1_fields: we=%b wd=%h wm=%b, required 1 1111 01", obs_iss[1].we, obs_iss[1].wd, obs_iss[1].wm);
            end
        end
        vecs++;
        if (hold_bad != 0) begin
            errs++; $display("FAIL simul_hold: %0d cycles with mem fields changing, required 0", hold_bad);
        end
    endtask

    task automatic test_round_robin();
        int exp_ports[7] = '{1, 2, 1, 2, 0, 1, 2};
        int n = 0;
        bit injected = 0;
        do_reset();
        c_lat = 2;
        while (obs_iss.size() < 7 && n < 200) begin
            if (obs_iss.size() < 6) begin
                if (!m_busy[1]) drive(1, 1'($urandom), rand_addr(1), 16'($urandom), 2'($urandom));
                if (!m_busy[2]) drive(2, 1'($urandom), rand_addr(2), 16'($urandom), 2'($urandom));
            end
            if (obs_iss.size() == 4 && !injected) begin
                drive(0, 1'b0, rand_addr(0), 16'($urandom), 2'b00);
                injected = 1;
            end
            tick(); n++;
        end
        wait_idle("round_robin", 60);
        vecs++;
        if (obs_iss.size() < 7) begin
            errs++; $display("FAIL rr_count: %0d grants, required at least 7", obs_iss.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                vecs++;
                if (int'(obs_iss[i].addr[21:20]) != exp_ports[i]) begin
                    errs++; $display("FAIL rr_grant[%0d]: port %0d, required %0d", i, obs_iss[i].addr[21:20], exp_ports[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [AB-1:0] a1;
        do_reset();
        c_lat = 4;
        a1 = rand_addr(2);
        drive(2, 1'b0, a1, 16'h0, 2'b00);
        tick();
        drive(2, 1'b1, a1 ^ 22'h1, 16'hFFFF, 2'b11);
        tick(); tick();
        drive(2, 1'b1, a1 ^ 22'h2, 16'hFFFF, 2'b11);
        wait_idle("overflow", 40);
        vecs++;
        if (bus.err !== 3'b100) begin
            errs++; $display("FAIL overflow_err: got %b, required 100", bus.err);
        end
        vecs++;
        if (obs_iss.size() != 1) begin
            errs++; $display("FAIL overflow_issue_count: got %0d, required 1", obs_iss.size());
        end else begin
            vecs++;
            if (obs_iss[0].addr !== a1 || obs_iss[0].we !== 1'b0) begin
                errs++; $display("FAIL overflow_cmd_kept: addr=%h we=%b, required %h 0", obs_iss[0].addr, obs_iss[0].we, a1);
            end
        end
        drive(2, 1'b0, rand_addr(2), 16'h0, 2'b00);
        wait_idle("overflow_after", 40);
        vecs++;
        if (obs_iss.size() != 2 || bus.err !== 3'b100) begin
            errs++; $display("FAIL overflow_sticky: issues=%0d err=%b, required 2 and 100", obs_iss.size(), bus.err);
        end
    endtask

    task automatic test_spurious_back_to_back();
        int t0, n, ack_cyc;
        do_reset();
        c_lat = 2;
        tick();
        bus.mem_ack = 1'b1; bus.mem_data_read = 16'hDEAD;
        tick(); tick(); tick();
        vecs++;
        if (obs_ack.size() != 0 || obs_iss.size() != 0 || bus.data_read !== 16'h0) begin
            errs++; $display("FAIL spurious_ack: acks=%0d issues=%0d data_read=%h, required 0 0 0000", obs_ack.size(), obs_iss.size(), bus.data_read);
        end
        t0 = cyc;
        drive(1, 1'b0, rand_addr(1), 16'h0, 2'b00);
        n = 0;
        while (obs_ack.size() == 0 && n < 30) begin tick(); n++; end
        vecs++;
        if (obs_ack.size() == 0) begin
            errs++; $display("FAIL b2b_first_ack: none within %0d cycles, required one", n);
        end else begin
            ack_cyc = obs_ack[0].cyc;
            drive(1, 1'b1, rand_addr(1), 16'h2222, 2'b10);
            wait_idle("b2b", 30);
            vecs++;
            if (obs_iss.size() != 2 || obs_ack.size() != 2) begin
                errs++; $display("FAIL b2b_counts: issues=%0d acks=%0d, required 2 2", obs_iss.size(), obs_ack.size());
            end else begin
                vecs++;
                if (obs_iss[0].cyc != t0 + 2 || obs_iss[1].cyc != ack_cyc + 2 || obs_iss[1].we !== 1'b1 || obs_ack[1].port != 1) begin
                    errs++; $display("FAIL b2b_timing: issue cycles %0d,%0d we=%b ackport=%0d, required %0d,%0d 1 1", obs_iss[0].cyc, obs_iss[1].cyc, obs_iss[1].we, obs_ack[1].port, t0 + 2, ack_cyc + 2);
                end
            end
            vecs++;
            if (bus.err !== 3'b000) begin
                errs++; $display("FAIL b2b_err: got %b, required 000", bus.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, t0;
        do_reset();
        c_lat = 2; rd_force = 1; rd_val = 16'hA5A5;
        drive(1, 1'b0, rand_addr(1), 16'h0, 2'b00);
        wait_idle("reset_mid_pre", 30);
        rd_force = 0; c_lat = 6;
        drive(1, 1'b0, rand_addr(1), 16'h0, 2'b00);
        tick();
        drive(1, 1'b0, rand_addr(1), 16'h0, 2'b00);
        n = 0;
        while (obs_iss.size() < 2 && n < 20) begin tick(); n++; end
        tick();
        vecs++;
        if (bus.err !== 3'b010 || bus.data_read !== 16'hA5A5 || obs_iss.size() != 2) begin
            errs++; $display("FAIL reset_mid_setup: err=%b data_read=%h issues=%0d, required 010 a5a5 2", bus.err, bus.data_read, obs_iss.size());
        end
        #3 reset = 1'b1;
        #1;
        vecs++;
        if ({bus.ack, bus.err, bus.mem_req, bus.data_read} !== 23'd0) begin
            errs++; $display("FAIL reset_mid_out: ack=%b err=%b mem_req=%b data_read=%h, required all 0", bus.ack, bus.err, bus.mem_req, bus.data_read);
        end
        vecs++;
        if ({bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm} !== 41'd0) begin
            errs++; $display("FAIL reset_mid_fields: %h, required 0", {bus.mem_we, bus.mem_address, bus.mem_data_write, bus.mem_wm});
        end
        model_clear();
        bus.mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (8) tick();
        vecs++;
        if (obs_ack.size() != 0) begin
            errs++; $display("FAIL reset_mid_no_ack: %0d acks, required 0", obs_ack.size());
        end
        c_lat = 3;
        t0 = cyc;
        drive(1, 1'b0, rand_addr(1), 16'h0, 2'b00);
        wait_idle("reset_mid_post", 30);
        vecs++;
        if (obs_ack.size() != 1 || exp_ack.size() != 1 || obs_iss.size() != 1) begin
            errs++; $display("FAIL reset_mid_post_count: acks=%0d issues=%0d, required 1 1", obs_ack.size(), obs_iss.size());
        end else begin
            vecs++;
            if (obs_ack[0].port != 1 || obs_ack[0].data !== exp_ack[0].data || obs_iss[0].cyc != t0 + 2) begin
                errs++; $display("FAIL reset_mid_post: port=%0d data=%h issue cyc=%0d, required 1 %h %0d", obs_ack[0].port, obs_ack[0].data, obs_iss[0].cyc, exp_ack[0].data, t0 + 2);
            end
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            c_lat = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0)
                drive(0, 1'($urandom), rand_addr(0), 16'($urandom), 2'($urandom));
            for (int p = 1; p < 3; p++)
                if ($urandom_range(0, 3) == 0)
                    drive(p, 1'($urandom), rand_addr(p), 16'($urandom), 2'($urandom));
            tick();
        end
        wait_idle("random", 200);
        vecs++;
        if (obs_iss.size() != exp_iss.size() || obs_ack.size() != exp_ack.size()) begin
            errs++; $display("FAIL random_counts: issues %0d/%0d acks %0d/%0d (got/required)", obs_iss.size(), exp_iss.size(), obs_ack.size(), exp_ack.size());
        end
        n = (obs_iss.size() < exp_iss.size()) ? obs_iss.size() : exp_iss.size();
        for (int i = 0; i < n; i++) begin
            vecs++;
            if (obs_iss[i].we !== exp_iss[i].we || obs_iss[i].addr !== exp_iss[i].addr || obs_iss[i].wd !== exp_iss[i].wd ||
                obs_iss[i].wm !== exp_iss[i].wm || obs_iss[i].cyc != exp_iss[i].cyc) begin
                errs++;
                $display("FAIL random_issue[%0d]: got we=%b addr=%h wd=%h wm=%b cyc=%0d, required we=%b addr=%h wd=%h wm=%b cyc=%0d", i,
                         obs_iss[i].we, obs_iss[i].addr, obs_iss[i].wd, obs_iss[i].wm, obs_iss[i].cyc,
                         exp_iss[i].we, exp_iss[i].addr, exp_iss[i].wd, exp_iss[i].wm, exp_iss[i].cyc);
            end
        end
        n = (obs_ack.size() < exp_ack.size()) ? obs_ack.size() : exp_ack.size();
        for (int i = 0; i < n; i++) begin
            vecs++;
            if (obs_ack[i].port != exp_ack[i].port || obs_ack[i].data !== exp_ack[i].data || obs_ack[i].cyc != exp_ack[i].cyc) begin
                errs++;
                $display("FAIL random_ack[%0d]: got port=%0d data=%h cyc=%0d, required port=%0d data=%h cyc=%0d", i,
                         obs_ack[i].port, obs_ack[i].data, obs_ack[i].cyc, exp_ack[i].port, exp_ack[i].data, exp_ack[i].cyc);
            end
        end
        vecs++;
        if (bus.err !== m_err) begin
            errs++; $display("FAIL random_err: got %b, required %b", bus.err, m_err);
        end
        vecs++;
        if (hold_bad != 0) begin
            errs++; $display("FAIL random_hold: %0d cycles with mem fields changing, required 0", hold_bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 3'b000; bus.we = 3'b000; bus.address = '0; bus.data_write = '0; bus.wm = '0;
        bus.mem_ack = 1'b0; bus.mem_data_read = 16'h0;
        c_lat = 2; rd_force = 0; rd_val = 16'h0;
        model_clear();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_overflow();
        test_spurious_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
